// File: rtl/cordic_pkg.sv
// Shared types and constants for the iterative CORDIC rotator.
package cordic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROTATE,
    DONE
  } cordic_state_e;

  localparam logic [15:0] CordicGainQ14 = 16'h26DD;
  localparam int          FracBits      = 14;
  localparam int          GuardBits     = 2;
  localparam int          MaxIterations = 16;
  localparam int          CntW          = $clog2(MaxIterations);

  // Clamp a guard-extended Q1.14 value to a 16-bit signed word.
  function automatic logic [15:0] sat_q14(input logic signed [15+GuardBits:0] v);
    logic signed [15+GuardBits:0] hi;
    logic signed [15+GuardBits:0] lo;
    hi = (16+GuardBits)'(32767);
    lo = -(16+GuardBits)'(32768);
    if (v > hi)      return 16'h7FFF;
    else if (v < lo) return 16'h8000;
    else             return v[15:0];
  endfunction

endpackage

// File: rtl/rom_cordic.sv
// Arctangent table: entry i holds atan(2^-i) in Q8.8 degrees, read combinationally.
module rom_cordic #(
  parameter int Width = 16
) (
  input  logic [3:0]       addr_i,
  output logic [Width-1:0] data_o
);

  always_comb begin
    data_o = '0;
    case (addr_i)
      4'd0:  data_o = Width'(16'd11520);
      4'd1:  data_o = Width'(16'd6801);
      4'd2:  data_o = Width'(16'd3593);
      4'd3:  data_o = Width'(16'd1824);
      4'd4:  data_o = Width'(16'd916);
      4'd5:  data_o = Width'(16'd458);
      4'd6:  data_o = Width'(16'd229);
      4'd7:  data_o = Width'(16'd115);
      4'd8:  data_o = Width'(16'd57);
      4'd9:  data_o = Width'(16'd29);
      4'd10: data_o = Width'(16'd14);
      4'd11: data_o = Width'(16'd7);
      4'd12: data_o = Width'(16'd4);
      4'd13: data_o = Width'(16'd2);
      4'd14: data_o = Width'(16'd1);
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/cordic_rotator.sv
// Rotation-mode CORDIC: Q8.8 degree angle in, Q1.14 cos/sin out, one micro-rotation per clock.
module cordic_rotator
  import cordic_pkg::*;
#(
  parameter int Width      = 16,
  parameter int Iterations = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] angle_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] cos_o,
  output logic [Width-1:0] sin_o
);

  localparam int              XW       = Width + GuardBits;
  localparam int              ZW       = Width + 1;
  localparam logic [CntW-1:0] LastIter = CntW'(Iterations - 1);

  cordic_state_e        r_state, w_state_nxt;
  logic signed [XW-1:0] r_x, r_y, w_x_nxt, w_y_nxt, w_x_sh, w_y_sh;
  logic signed [ZW-1:0] r_z, w_z_nxt, w_atan;
  logic [CntW-1:0]      r_cnt;
  logic [Width-1:0]     w_rom, r_cos, r_sin;
  logic                 w_accept, w_last, w_d_pos;

  rom_cordic #(.Width(Width)) u_rom (
    .addr_i (r_cnt),
    .data_o (w_rom)
  );

  assign w_accept = in_valid_i && (r_state == IDLE);
  assign w_last   = (r_state == ROTATE) && (r_cnt == LastIter);
  assign w_atan   = $signed({1'b0, w_rom});
  assign w_d_pos  = !r_z[ZW-1];
  assign w_x_sh   = r_x >>> r_cnt;
  assign w_y_sh   = r_y >>> r_cnt;

  // Single shared shift/add-sub stage; direction follows the sign of the residual angle.
  always_comb begin
    w_x_nxt = r_x;
    w_y_nxt = r_y;
    w_z_nxt = r_z;
    if (w_d_pos) begin
      w_x_nxt = r_x - w_y_sh;
      w_y_nxt = r_y + w_x_sh;
      w_z_nxt = r_z - w_atan;
    end else begin
      w_x_nxt = r_x + w_y_sh;
      w_y_nxt = r_y - w_x_sh;
      w_z_nxt = r_z + w_atan;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (in_valid_i)  w_state_nxt = ROTATE;
      ROTATE:  if (w_last)      w_state_nxt = DONE;
      DONE:    if (out_ready_i) w_state_nxt = IDLE;
      default:                  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_x   <= '0;
      r_y   <= '0;
      r_z   <= '0;
      r_cnt <= '0;
      r_cos <= '0;
      r_sin <= '0;
    end else if (w_accept) begin
      r_x   <= XW'(CordicGainQ14);
      r_y   <= '0;
      r_z   <= {angle_i[Width-1], angle_i};
      r_cnt <= '0;
    end else if (r_state == ROTATE) begin
      r_x   <= w_x_nxt;
      r_y   <= w_y_nxt;
      r_z   <= w_z_nxt;
      r_cnt <= r_cnt + 1'b1;
      // Capture straight from the final stage so the result lands on entry to DONE.
      if (w_last) begin
        r_cos <= sat_q14(w_x_nxt);
        r_sin <= sat_q14(w_y_nxt);
      end
    end
  end

  assign in_ready_o  = (r_state == IDLE);
  assign out_valid_o = (r_state == DONE);
  assign cos_o       = r_cos;
  assign sin_o       = r_sin;

endmodule
